// File: rtl/mod_leds_pwm_pkg.sv
// rtl/mod_leds_pwm_pkg.sv - register word indices and address-decode helpers for the LED PWM peripheral
package mod_leds_pwm_pkg;

    // Word index taken from daddr[6:2].
    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_MASK      = 5'd0;   // 0x00
    localparam reg_idx_t REG_SET       = 5'd1;   // 0x04
    localparam reg_idx_t REG_CLR       = 5'd2;   // 0x08
    localparam reg_idx_t REG_PRESC     = 5'd3;   // 0x0C
    localparam reg_idx_t REG_BLINK     = 5'd4;   // 0x10
    localparam reg_idx_t REG_BPER      = 5'd5;   // 0x14
    localparam reg_idx_t REG_DUTY_BASE = 5'd16;  // 0x40

    localparam int BPER_W = 8;

    // The DUTY window occupies word indices 16..31, so bit 4 alone selects it.
    function automatic logic is_duty(input reg_idx_t idx);
        return idx[4];
    endfunction

    function automatic logic [3:0] duty_slot(input reg_idx_t idx);
        return idx[3:0];
    endfunction

endpackage

// File: rtl/mod_leds_timebase.sv
// rtl/mod_leds_timebase.sv - prescaler, PWM period counter and wrap strobe; blink phase under LEDS_BLINK_EN
module mod_leds_timebase
    import mod_leds_pwm_pkg::*;
#(
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic               i_presc_wr,
    output logic [PWM_W-1:0]   o_pwm_cnt,
    output logic               o_wrap
`ifdef LEDS_BLINK_EN
    ,
    input  logic [BPER_W-1:0]  i_bper,
    input  logic               i_bper_wr,
    output logic               o_blink_ph
`endif
);

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic               w_tick;
    logic               w_wrap;

    assign w_tick = (r_presc_cnt == i_presc);
    assign w_wrap = w_tick && (r_pwm_cnt == {PWM_W{1'b1}});

    always_ff @(negedge clk) begin
        if (rst) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            // A PRESC write restarts the prescale interval from zero.
            if (i_presc_wr || w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            end
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            end
        end
    end

    assign o_pwm_cnt = r_pwm_cnt;
    assign o_wrap    = w_wrap;

`ifdef LEDS_BLINK_EN
    logic [BPER_W-1:0] r_blink_cnt;
    logic              r_blink_ph;

    // Blink half-period is measured in whole PWM periods.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (i_bper_wr) begin
            r_blink_cnt <= '0;
        end else if (w_wrap) begin
            if (r_blink_cnt == i_bper) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + BPER_W'(1);
            end
        end
    end

    assign o_blink_ph = r_blink_ph;
`endif

endmodule

// File: rtl/mod_leds_pwm.sv
// rtl/mod_leds_pwm.sv - memory-mapped LED controller: mask, per-LED shadowed PWM duty, optional blink
// Optional feature macro: LEDS_BLINK_EN (adds BLINK at 0x10 and BPER at 0x14).
module mod_leds_pwm
    import mod_leds_pwm_pkg::*;
#(
    parameter int N_LEDS  = 8,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de,
    input  logic [31:0]       daddr,
    input  logic              drw,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic [N_LEDS-1:0] leds
);

    reg_idx_t           w_idx;
    logic               w_wr;
    logic               w_presc_wr;
    logic [31:0]        w_rdata;

    logic [N_LEDS-1:0]  r_mask;
    logic [PRESC_W-1:0] r_presc;
    logic [PWM_W-1:0]   r_duty_pend [N_LEDS];
    logic [PWM_W-1:0]   r_duty_act  [N_LEDS];
    logic [N_LEDS-1:0]  r_leds;

    logic [PWM_W-1:0]   w_pwm_cnt;
    logic               w_wrap;
    logic [N_LEDS-1:0]  w_pwm_on;
    logic [N_LEDS-1:0]  w_blank;

    assign w_idx      = daddr[6:2];
    assign w_wr       = de && drw;
    assign w_presc_wr = w_wr && (w_idx == REG_PRESC);

    // Address bits outside [6:2] and data bits above each field width are don't-care.
    logic w_unused;
    assign w_unused = ^{daddr, din};

`ifdef LEDS_BLINK_EN
    logic [N_LEDS-1:0]  r_blink;
    logic [BPER_W-1:0]  r_bper;
    logic               w_bper_wr;
    logic               w_blink_ph;

    assign w_bper_wr = w_wr && (w_idx == REG_BPER);

    always_ff @(negedge clk) begin
        if (rst) begin
            r_blink <= '0;
            r_bper  <= '0;
        end else if (w_wr) begin
            if (w_idx == REG_BLINK) r_blink <= din[N_LEDS-1:0];
            if (w_idx == REG_BPER)  r_bper  <= din[BPER_W-1:0];
        end
    end

    assign w_blank = r_blink & {N_LEDS{~w_blink_ph}};
`else
    assign w_blank = '0;
`endif

    mod_leds_timebase #(
        .PWM_W   (PWM_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .i_presc    (r_presc),
        .i_presc_wr (w_presc_wr),
        .o_pwm_cnt  (w_pwm_cnt),
        .o_wrap     (w_wrap)
`ifdef LEDS_BLINK_EN
        ,
        .i_bper     (r_bper),
        .i_bper_wr  (w_bper_wr),
        .o_blink_ph (w_blink_ph)
`endif
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            r_mask  <= '1;
            r_presc <= '0;
        end else if (w_wr) begin
            case (w_idx)
                REG_MASK:  r_mask  <= din[N_LEDS-1:0];
                REG_SET:   r_mask  <= r_mask | din[N_LEDS-1:0];
                REG_CLR:   r_mask  <= r_mask & ~din[N_LEDS-1:0];
                REG_PRESC: r_presc <= din[PRESC_W-1:0];
                default:   ;
            endcase
        end
    end

    // Active duties only change at the period boundary, so a period never mixes two duties.
    always_ff @(negedge clk) begin
        for (int i = 0; i < N_LEDS; i++) begin
            if (rst) begin
                r_duty_pend[i] <= '1;
                r_duty_act[i]  <= '1;
            end else begin
                if (w_wr && is_duty(w_idx) && (duty_slot(w_idx) == 4'(i))) begin
                    r_duty_pend[i] <= din[PWM_W-1:0];
                end
                if (w_wrap) begin
                    r_duty_act[i] <= r_duty_pend[i];
                end
            end
        end
    end

    // All-ones duty is treated as fully on so the LED never drops for the last count.
    always_comb begin
        w_pwm_on = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            w_pwm_on[i] = (r_duty_act[i] == {PWM_W{1'b1}}) || (w_pwm_cnt < r_duty_act[i]);
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_leds <= '1;
        end else begin
            r_leds <= r_mask & w_pwm_on & ~w_blank;
        end
    end

    assign leds = r_leds;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_MASK:  w_rdata = 32'(r_mask);
            REG_PRESC: w_rdata = 32'(r_presc);
`ifdef LEDS_BLINK_EN
            REG_BLINK: w_rdata = 32'(r_blink);
            REG_BPER:  w_rdata = 32'(r_bper);
`endif
            default: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    if (is_duty(w_idx) && (duty_slot(w_idx) == 4'(i))) begin
                        w_rdata = 32'(r_duty_pend[i]);
                    end
                end
            end
        endcase
    end

    assign dout = de ? w_rdata : 32'h0;

endmodule

// File: tb/tb_mod_leds_pwm.sv
// tb/tb_mod_leds_pwm.sv - scoreboard bench for mod_leds_pwm; blink cases run when LEDS_BLINK_EN is defined
module tb_mod_leds_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic [31:0] daddr;
    logic        drw;
    logic [31:0] din;
    logic [31:0] dout;
    logic [7:0]  leds;

    always #5 clk = ~clk;

    mod_leds_pwm #(
        .N_LEDS  (8),
        .PWM_W   (8),
        .PRESC_W (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .de    (de),
        .daddr (daddr),
        .drw   (drw),
        .din   (din),
        .dout  (dout),
        .leds  (leds)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    // Outputs change on negedge; sampling 1ns after posedge sits mid-phase.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        de    = 1'b1;
        drw   = 1'b1;
        daddr = a;
        din   = d;
        @(negedge clk);
        @(posedge clk);
        #1;
        de  = 1'b0;
        drw = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        de    = 1'b1;
        drw   = 1'b0;
        daddr = a;
        sb_push(tag, exp);
        #1;
        sb_pop(dout);
        de = 1'b0;
    endtask

    task automatic chk_leds(input string tag, input logic [7:0] exp);
        sb_push(tag, 32'(exp));
        sb_pop(32'(leds));
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            if (leds[0]) hi++;
        end
    endtask

    task automatic wait_rise(input string tag, input int limit);
        logic prev;
        bit   hit;
        hit  = 1'b0;
        prev = leds[0];
        for (int k = 0; k < limit && !hit; k++) begin
            cyc();
            if (!prev && leds[0]) hit = 1'b1;
            prev = leds[0];
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (leds[0] == lvl && n < 5000) begin
            n++;
            cyc();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int run;

        rst   = 1'b1;
        de    = 1'b0;
        drw   = 1'b0;
        daddr = '0;
        din   = '0;
        repeat (3) cyc();
        chk_leds("in_reset_leds", 8'hFF);
        rst = 1'b0;
        cyc();

        chk_leds("rst_leds", 8'hFF);
        rd("rst_mask",     32'h00, 32'h0000_00FF);
        rd("rst_duty0",    32'h40, 32'h0000_00FF);
        rd("rst_duty7",    32'h5C, 32'h0000_00FF);
        rd("rst_presc",    32'h0C, 32'h0);
        rd("duty8_absent", 32'h60, 32'h0);
        rd("set_reads0",   32'h04, 32'h0);
        rd("hole_reads0",  32'h20, 32'h0);

        daddr = 32'h00;
        de    = 1'b0;
        sb_push("de0_dout", 32'h0);
        #1;
        sb_pop(dout);

        wr(32'h00, 32'h5A);
        chk_leds("mask_lat0", 8'hFF);
        cyc();
        chk_leds("mask_5a", 8'h5A);
        wr(32'h08, 32'h0F);
        cyc();
        chk_leds("clr_50", 8'h50);
        wr(32'h04, 32'h01);
        cyc();
        chk_leds("set_51", 8'h51);
        rd("mask_rb",    32'h00, 32'h51);
        rd("addr_alias", 32'h1234_5680, 32'h51);

        wr(32'h40, 32'h40);
        rd("duty_pend", 32'h40, 32'h40);
        wr(32'h00, 32'h01);
        repeat (300) cyc();
        count_high(256, hi);
        check("pwm64_a", 32'(hi), 32'd64);
        count_high(256, hi);
        check("pwm64_b", 32'(hi), 32'd64);

        wait_rise("rise_shadow", 600);
        repeat (99) cyc();
        wr(32'h40, 32'h80);
        rd("shadow_rd", 32'h40, 32'h80);
        count_high(150, hi);
        check("shadow_hold", 32'(hi), 32'd0);
        count_high(256, hi);
        check("shadow_new", 32'(hi), 32'd128);

        wr(32'h0C, 32'h3);
        rd("presc_rb", 32'h0C, 32'h3);
        wait_rise("rise_p3", 2000);
        run_len(1'b1, run);
        check("p3_run", 32'(run), 32'd512);
        wait_rise("rise_p3b", 2000);
        wr(32'h0C, 32'h3);
        run_len(1'b1, run);
        check("p3_restart_run", 32'(run + 1), 32'd514);

        wr(32'h44, 32'h33);
        rd("duty1_pend", 32'h44, 32'h33);
        rst = 1'b1;
        cyc();
        chk_leds("rst_mid", 8'hFF);
        rst = 1'b0;
        rd("rst_pend_drop", 32'h44, 32'hFF);
        rd("rst_presc2",    32'h0C, 32'h0);
        rd("rst_mask2",     32'h00, 32'hFF);

`ifdef LEDS_BLINK_EN
        wr(32'h10, 32'h01);
        wr(32'h14, 32'h01);
        rd("blink_rb", 32'h10, 32'h01);
        rd("bper_rb",  32'h14, 32'h01);
        wait_rise("blink_rise", 3000);
        run_len(1'b1, run);
        check("blink_on", 32'(run), 32'd512);
        run_len(1'b0, run);
        check("blink_off", 32'(run), 32'd512);
        repeat (100) cyc();
        rst = 1'b1;
        cyc();
        chk_leds("blink_rst", 8'hFF);
        rst = 1'b0;
        rd("blink_rst_rb", 32'h10, 32'h0);
`else
        wr(32'h10, 32'hFF);
        wr(32'h14, 32'hFF);
        rd("blink_absent", 32'h10, 32'h0);
        rd("bper_absent",  32'h14, 32'h0);
        cyc();
        chk_leds("no_blink_leds", 8'hFF);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
